// File: rtl/dma_read_streamer_pkg.sv
// dma_read_streamer_pkg
// Shared types and constants for the DMA read streamer slice:
//   - cacheline address/data widths
//   - burst length encodings (RLEN_1/RLEN_2/RLEN_4) and a decode helper
//   - t_rdstream_state FSM encoding
//   - DMA control/status and read request/response channel structs
package dma_read_streamer_pkg;

  localparam int unsigned CLADDR_WIDTH = 42;
  localparam int unsigned CLDATA_WIDTH = 512;

  localparam logic [1:0] RLEN_1 = 2'b00;
  localparam logic [1:0] RLEN_2 = 2'b01;
  localparam logic [1:0] RLEN_4 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_ACTIVE,
    REQUEST,
    DRAIN,
    DONE
  } t_rdstream_state;

  typedef struct packed {
    logic                    start;
    logic [CLADDR_WIDTH-1:0] addr;
    logic                    async;
    logic [3:0]              regs;
  } t_dma_control;

  typedef struct packed {
    logic active;
  } t_dma_status;

  typedef struct packed {
    logic                    re;
    logic [1:0]              rlength;
    logic [CLADDR_WIDTH-1:0] raddr;
  } t_dma_tx_read;

  typedef struct packed {
    logic                    rvalid;
    logic [CLDATA_WIDTH-1:0] rdata;
    logic                    ralmostfull;
  } t_dma_rx_read;

  // Number of cachelines carried by a burst encoding.
  function automatic logic [2:0] rlen_lines(input logic [1:0] rlength);
    case (rlength)
      RLEN_4:  return 3'd4;
      RLEN_2:  return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dma_read_streamer_req_gen.sv
// dma_read_req_gen
// Burst selection plus read address / remaining-line bookkeeping.
// Ports:
//   clk, resetn      clock, async active-low reset
//   load             capture load_addr/load_lines (accepted op_start)
//   load_addr        first cacheline address
//   load_lines       cachelines to read
//   issue            a burst of burst_len lines was issued this cycle
//   raddr            address of the next burst
//   remaining        lines not yet requested
//   rlength          encoding of the next burst (largest aligned fit)
//   burst_len        lines in the next burst (1, 2 or 4)
module dma_read_req_gen
  import dma_read_streamer_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [CLADDR_WIDTH-1:0] load_addr,
  input  logic [15:0]             load_lines,
  input  logic                    issue,
  output logic [CLADDR_WIDTH-1:0] raddr,
  output logic [15:0]             remaining,
  output logic [1:0]              rlength,
  output logic [2:0]              burst_len
);

  always_comb begin
    rlength = RLEN_1;
    if (remaining >= 16'd4 && raddr[1:0] == 2'b00) begin
      rlength = RLEN_4;
    end else if (remaining >= 16'd2 && raddr[0] == 1'b0) begin
      rlength = RLEN_2;
    end
    burst_len = rlen_lines(rlength);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      raddr     <= '0;
      remaining <= '0;
    end else if (load) begin
      raddr     <= load_addr;
      remaining <= load_lines;
    end else if (issue) begin
      raddr     <= raddr + CLADDR_WIDTH'(burst_len);
      remaining <= remaining - 16'(burst_len);
    end
  end

endmodule

// File: rtl/dma_read_streamer.sv
// dma_read_streamer
// Streams op_lines cachelines from host memory via the DMA read channel into
// a fifobram, with a credit limit on outstanding lines.
// Optional feature: define PIPEARCH_READ_PERF_EN to build perf_busy/perf_stall
// saturating counters; otherwise both outputs are constant 0.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   op_start/op_addr/op_lines/op_waddr/op_wfifobram   operation request
//   op_ready, op_done, op_err   idle flag, completion pulse, sticky stray-rvalid
//   dma_control, dma_status     DMA control out / status in
//   tx_read, rx_read            read requests out / responses in
//   wr_we/wr_waddr/wr_wdata/wr_wfifobram, wr_almostfull   fifobram write port
//   perf_busy, perf_stall       performance counters
module dma_read_streamer
  import dma_read_streamer_pkg::*;
#(
  parameter int unsigned LOG2_DEPTH      = 9,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    op_start,
  input  logic [CLADDR_WIDTH-1:0] op_addr,
  input  logic [15:0]             op_lines,
  input  logic [LOG2_DEPTH-1:0]   op_waddr,
  input  logic [1:0]              op_wfifobram,
  output logic                    op_ready,
  output logic                    op_done,
  output logic                    op_err,
  output t_dma_control            dma_control,
  input  t_dma_status             dma_status,
  output t_dma_tx_read            tx_read,
  input  t_dma_rx_read            rx_read,
  output logic                    wr_we,
  output logic [LOG2_DEPTH-1:0]   wr_waddr,
  output logic [CLDATA_WIDTH-1:0] wr_wdata,
  output logic [1:0]              wr_wfifobram,
  input  logic                    wr_almostfull,
  output logic [31:0]             perf_busy,
  output logic [31:0]             perf_stall
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  t_rdstream_state         state;
  logic [CLADDR_WIDTH-1:0] raddr;
  logic [15:0]             remaining;
  logic [1:0]              rlength;
  logic [2:0]              burst_len;
  logic [OUT_W-1:0]        outstanding;
  logic [OUT_W+2:0]        credit_sum;
  logic                    issue;
  logic                    rsp_accept;
  logic                    start_accept;
  logic [LOG2_DEPTH-1:0]   wptr;

  assign start_accept = (state == IDLE) && op_start;
  assign rsp_accept   = rx_read.rvalid && (outstanding != '0);

  always_comb begin
    credit_sum = {3'b000, outstanding} + (OUT_W+3)'(burst_len);
    issue      = (state == REQUEST) && (remaining != 16'd0) &&
                 !rx_read.ralmostfull && !wr_almostfull &&
                 (credit_sum <= (OUT_W+3)'(MAX_OUTSTANDING));
  end

  always_comb begin
    tx_read         = '0;
    tx_read.re      = issue;
    tx_read.rlength = rlength;
    tx_read.raddr   = raddr;
  end

  dma_read_req_gen u_req_gen (
    .clk        (clk),
    .resetn     (resetn),
    .load       (start_accept),
    .load_addr  (op_addr),
    .load_lines (op_lines),
    .issue      (issue),
    .raddr      (raddr),
    .remaining  (remaining),
    .rlength    (rlength),
    .burst_len  (burst_len)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op_ready    <= 1'b1;
      op_done     <= 1'b0;
      dma_control <= '0;
    end else begin
      dma_control.start <= 1'b0;
      op_done           <= 1'b0;
      case (state)
        IDLE: begin
          if (op_start) begin
            op_ready <= 1'b0;
            if (op_lines == 16'd0) begin
              state   <= DONE;
              op_done <= 1'b1;
            end else begin
              state             <= ARM;
              dma_control.start <= 1'b1;
              dma_control.addr  <= op_addr;
            end
          end
        end
        ARM:         state <= WAIT_ACTIVE;
        WAIT_ACTIVE: if (dma_status.active) state <= REQUEST;
        REQUEST: begin
          // Leave on the edge that issues the final burst.
          if (remaining == 16'd0 || (issue && remaining == 16'(burst_len))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // outstanding==0 here means the last write strobe is on the port now.
          if (outstanding == '0) begin
            state   <= DONE;
            op_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

  // Credit counter: issue and response in the same cycle net out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding
                     + (issue ? OUT_W'(burst_len) : '0)
                     - (rsp_accept ? OUT_W'(1) : '0);
    end
  end

  // A stray response in the same cycle as op_start still flags the error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_err <= 1'b0;
    end else if (rx_read.rvalid && outstanding == '0) begin
      op_err <= 1'b1;
    end else if (start_accept) begin
      op_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_we        <= 1'b0;
      wr_waddr     <= '0;
      wr_wdata     <= '0;
      wr_wfifobram <= 2'b01;
      wptr         <= '0;
    end else begin
      wr_we <= rsp_accept;
      if (start_accept) begin
        wptr         <= op_waddr;
        wr_wfifobram <= op_wfifobram;
      end else if (rsp_accept) begin
        wr_waddr <= wptr;
        wr_wdata <= rx_read.rdata;
        wptr     <= wptr + LOG2_DEPTH'(1);
      end
    end
  end

`ifdef PIPEARCH_READ_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (start_accept) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (state != IDLE && perf_busy != '1) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if (state == REQUEST && remaining != 16'd0 && !issue && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_dma_read_streamer.sv
// tb_dma_read_streamer
// Directed self-checking bench for dma_read_streamer. A cycle task samples
// DUT outputs on the falling edge and drives inputs just after the rising
// edge; a small in-order memory model answers read requests.
module tb_dma_read_streamer;
  import dma_read_streamer_pkg::*;

  localparam int unsigned LOG2_DEPTH = 9;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    op_start;
  logic [CLADDR_WIDTH-1:0] op_addr;
  logic [15:0]             op_lines;
  logic [LOG2_DEPTH-1:0]   op_waddr;
  logic [1:0]              op_wfifobram;
  logic                    op_ready, op_done, op_err;
  t_dma_control            dma_control;
  t_dma_status             dma_status;
  t_dma_tx_read            tx_read;
  t_dma_rx_read            rx_read;
  logic                    wr_we;
  logic [LOG2_DEPTH-1:0]   wr_waddr;
  logic [CLDATA_WIDTH-1:0] wr_wdata;
  logic [1:0]              wr_wfifobram;
  logic                    wr_almostfull;
  logic [31:0]             perf_busy, perf_stall;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int re_cnt = 0;
  int resp_budget = 1000000;

  logic [CLADDR_WIDTH-1:0] pend[$];
  logic [CLADDR_WIDTH-1:0] req_addr[$];
  logic [1:0]              req_len[$];
  logic [LOG2_DEPTH-1:0]   wa_log[$];
  logic [CLDATA_WIDTH-1:0] wd_log[$];
  logic [1:0]              wf_log[$];

  always #5 clk = ~clk;

  dma_read_streamer #(.LOG2_DEPTH(LOG2_DEPTH), .MAX_OUTSTANDING(16)) dut (
    .clk(clk), .resetn(resetn),
    .op_start(op_start), .op_addr(op_addr), .op_lines(op_lines),
    .op_waddr(op_waddr), .op_wfifobram(op_wfifobram),
    .op_ready(op_ready), .op_done(op_done), .op_err(op_err),
    .dma_control(dma_control), .dma_status(dma_status),
    .tx_read(tx_read), .rx_read(rx_read),
    .wr_we(wr_we), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata),
    .wr_wfifobram(wr_wfifobram), .wr_almostfull(wr_almostfull),
    .perf_busy(perf_busy), .perf_stall(perf_stall)
  );

  function automatic logic [CLDATA_WIDTH-1:0] data_of(input logic [CLADDR_WIDTH-1:0] a);
    logic [63:0] w;
    w = {22'h0, a} ^ 64'hC0DE_5A5A_0000_0000;
    return {8{w}};
  endfunction

  task automatic tick();
    int n;
    @(negedge clk);
    if (tx_read.re) begin
      req_addr.push_back(tx_read.raddr);
      req_len.push_back(tx_read.rlength);
      re_cnt++;
      n = (tx_read.rlength == 2'b11) ? 4 : (tx_read.rlength == 2'b01) ? 2 : 1;
      for (int i = 0; i < n; i++) pend.push_back(tx_read.raddr + CLADDR_WIDTH'(i));
    end
    if (wr_we) begin
      wa_log.push_back(wr_waddr);
      wd_log.push_back(wr_wdata);
      wf_log.push_back(wr_wfifobram);
    end
    if (op_done) done_cnt++;
    if (dma_control.start) start_cnt++;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    if (resp_budget > 0 && pend.size() > 0) begin
      rx_read.rvalid = 1'b1;
      rx_read.rdata  = data_of(pend.pop_front());
      resp_budget--;
    end else begin
      rx_read.rvalid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    req_addr.delete(); req_len.delete();
    wa_log.delete(); wd_log.delete(); wf_log.delete();
  endtask

  task automatic start_op(input logic [CLADDR_WIDTH-1:0] a, input logic [15:0] n,
                          input logic [LOG2_DEPTH-1:0] wa, input logic [1:0] code);
    op_start = 1'b1; op_addr = a; op_lines = n; op_waddr = wa; op_wfifobram = code;
    tick();
  endtask

  task automatic run_until_done(input int max, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; op_start = 1'b0; op_addr = '0; op_lines = '0; op_waddr = '0;
    op_wfifobram = 2'b00; dma_status = '0; dma_status.active = 1'b1;
    rx_read = '0; wr_almostfull = 1'b0;
    #12;
    n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
    n_vec++; if (op_done !== 1'b0) begin n_err++; $display("FAIL reset_op_done got %b want 0", op_done); end
    n_vec++; if (op_err !== 1'b0) begin n_err++; $display("FAIL reset_op_err got %b want 0", op_err); end
    n_vec++; if (dma_control !== '0) begin n_err++; $display("FAIL reset_dma_control got %h want 0", dma_control); end
    n_vec++; if (tx_read.re !== 1'b0) begin n_err++; $display("FAIL reset_re got %b want 0", tx_read.re); end
    n_vec++; if (wr_we !== 1'b0 || wr_waddr !== '0 || wr_wdata !== '0) begin
      n_err++; $display("FAIL reset_wr got we=%b waddr=%0d want 0/0/0", wr_we, wr_waddr); end
    n_vec++; if (wr_wfifobram !== 2'b01) begin n_err++; $display("FAIL reset_wfifobram got %b want 01", wr_wfifobram); end
    n_vec++; if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin
      n_err++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_busy, perf_stall); end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_aligned();
    bit ok;
    int s0, d0;
    clear_logs();
    s0 = start_cnt; d0 = done_cnt;
    start_op(42'h100, 16'd8, 9'd5, 2'b10);
    tick(); tick();
    // busy: this start must be ignored
    op_start = 1'b1; op_addr = 42'h900; op_lines = 16'd4; tick();
    run_until_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL aligned_done got timeout want op_done"); end
    n_vec++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL aligned_ready_after got %b want 1", op_ready); end
    tick();
    n_vec++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL aligned_done_pulses got %0d want 1", done_cnt - d0); end
    n_vec++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL aligned_starts got %0d want 1", start_cnt - s0); end
    n_vec++; if (dma_control.addr !== 42'h100) begin n_err++; $display("FAIL aligned_ctrl_addr got %h want 100", dma_control.addr); end
    n_vec++; if (req_addr.size() != 2) begin n_err++; $display("FAIL aligned_nreq got %0d want 2", req_addr.size()); end
    for (int i = 0; i < req_addr.size() && i < 2; i++) begin
      n_vec++; if (req_addr[i] !== 42'h100 + 42'(4*i) || req_len[i] !== RLEN_4) begin
        n_err++; $display("FAIL aligned_req%0d got %h/%b want %h/11", i, req_addr[i], req_len[i], 42'h100 + 42'(4*i)); end
    end
    n_vec++; if (wa_log.size() != 8) begin n_err++; $display("FAIL aligned_nwr got %0d want 8", wa_log.size()); end
    for (int i = 0; i < wa_log.size() && i < 8; i++) begin
      n_vec++; if (wa_log[i] !== 9'(5 + i) || wd_log[i] !== data_of(42'h100 + 42'(i)) || wf_log[i] !== 2'b10) begin
        n_err++; $display("FAIL aligned_wr%0d got waddr=%0d code=%b want waddr=%0d code=10", i, wa_log[i], wf_log[i], 5 + i); end
    end
    n_vec++; if (op_err !== 1'b0) begin n_err++; $display("FAIL aligned_err got %b want 0", op_err); end
  endtask

  task automatic test_unaligned();
    bit ok;
    int r0;
    logic [CLADDR_WIDTH-1:0] ea [3];
    logic [1:0] el [3];
    ea[0] = 42'h101; ea[1] = 42'h102; ea[2] = 42'h104;
    el[0] = 2'b00;   el[1] = 2'b01;   el[2] = 2'b11;
    clear_logs();
    dma_status.active = 1'b0;
    r0 = re_cnt;
    start_op(42'h101, 16'd7, 9'd0, 2'b11);
    repeat (6) tick();
    n_vec++; if (re_cnt != r0) begin n_err++; $display("FAIL wait_active_re got %0d reqs want 0", re_cnt - r0); end
    dma_status.active = 1'b1;
    run_until_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL unaligned_done got timeout want op_done"); end
    n_vec++; if (req_addr.size() != 3) begin n_err++; $display("FAIL unaligned_nreq got %0d want 3", req_addr.size()); end
    for (int i = 0; i < req_addr.size() && i < 3; i++) begin
      n_vec++; if (req_addr[i] !== ea[i] || req_len[i] !== el[i]) begin
        n_err++; $display("FAIL unaligned_req%0d got %h/%b want %h/%b", i, req_addr[i], req_len[i], ea[i], el[i]); end
    end
    n_vec++; if (wa_log.size() != 7) begin n_err++; $display("FAIL unaligned_nwr got %0d want 7", wa_log.size()); end
    for (int i = 0; i < wa_log.size() && i < 7; i++) begin
      n_vec++; if (wa_log[i] !== 9'(i) || wd_log[i] !== data_of(42'h101 + 42'(i)) || wf_log[i] !== 2'b11) begin
        n_err++; $display("FAIL unaligned_wr%0d got waddr=%0d code=%b want waddr=%0d code=11", i, wa_log[i], wf_log[i], i); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [LOG2_DEPTH-1:0] ew [4];
    ew[0] = 9'd510; ew[1] = 9'd511; ew[2] = 9'd0; ew[3] = 9'd1;
    clear_logs();
    start_op(42'h200, 16'd4, 9'd510, 2'b01);
    run_until_done(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_done got timeout want op_done"); end
    n_vec++; if (wa_log.size() != 4) begin n_err++; $display("FAIL wrap_nwr got %0d want 4", wa_log.size()); end
    for (int i = 0; i < wa_log.size() && i < 4; i++) begin
      n_vec++; if (wa_log[i] !== ew[i] || wd_log[i] !== data_of(42'h200 + 42'(i))) begin
        n_err++; $display("FAIL wrap_wr%0d got waddr=%0d want %0d", i, wa_log[i], ew[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0;
    clear_logs();
    start_op(42'h300, 16'd16, 9'h40, 2'b00);
    for (int i = 0; i < 50 && req_addr.size() == 0; i++) tick();
    rx_read.ralmostfull = 1'b1;
    r0 = re_cnt;
    repeat (20) tick();
    n_vec++; if (re_cnt != r0) begin n_err++; $display("FAIL bp_window_re got %0d reqs want 0", re_cnt - r0); end
    rx_read.ralmostfull = 1'b0;
    run_until_done(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_done got timeout want op_done"); end
    n_vec++; if (req_addr.size() != 4) begin n_err++; $display("FAIL bp_nreq got %0d want 4", req_addr.size()); end
    n_vec++; if (wa_log.size() != 16) begin n_err++; $display("FAIL bp_nwr got %0d want 16", wa_log.size()); end
    for (int i = 0; i < wa_log.size() && i < 16; i++) begin
      n_vec++; if (wa_log[i] !== 9'(64 + i) || wd_log[i] !== data_of(42'h300 + 42'(i))) begin
        n_err++; $display("FAIL bp_wr%0d got waddr=%0d want %0d", i, wa_log[i], 64 + i); end
    end
`ifdef PIPEARCH_READ_PERF_EN
    n_vec++; if (!(perf_stall >= 32'd20)) begin n_err++; $display("FAIL bp_perf_stall got %0d want >=20", perf_stall); end
    n_vec++; if (!(perf_busy > perf_stall)) begin n_err++; $display("FAIL bp_perf_busy got %0d want >%0d", perf_busy, perf_stall); end
`else
    n_vec++; if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin
      n_err++; $display("FAIL bp_perf_off got %0d/%0d want 0/0", perf_busy, perf_stall); end
`endif
  endtask

  task automatic test_credit();
    bit ok;
    int w0;
    clear_logs();
    resp_budget = 0;
    start_op(42'h400, 16'd24, 9'h80, 2'b10);
    repeat (15) tick();
    n_vec++; if (req_addr.size() != 4 || pend.size() != 16) begin
      n_err++; $display("FAIL credit_cap got %0d reqs/%0d lines want 4/16", req_addr.size(), pend.size()); end
    resp_budget = 1;
    repeat (6) tick();
    n_vec++; if (req_addr.size() != 4) begin n_err++; $display("FAIL credit_15 got %0d reqs want 4", req_addr.size()); end
    resp_budget = 3;
    repeat (6) tick();
    n_vec++; if (req_addr.size() != 5) begin n_err++; $display("FAIL credit_12 got %0d reqs want 5", req_addr.size()); end
    resp_budget = 1000000;
    run_until_done(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL credit_done got timeout want op_done"); end
    n_vec++; if (req_addr.size() != 6) begin n_err++; $display("FAIL credit_nreq got %0d want 6", req_addr.size()); end
    n_vec++; if (wa_log.size() != 24) begin n_err++; $display("FAIL credit_nwr got %0d want 24", wa_log.size()); end
    for (int i = 0; i < wa_log.size() && i < 24; i++) begin
      n_vec++; if (wa_log[i] !== 9'(128 + i) || wd_log[i] !== data_of(42'h400 + 42'(i))) begin
        n_err++; $display("FAIL credit_wr%0d got waddr=%0d want %0d", i, wa_log[i], 128 + i); end
    end
    n_vec++; if (op_err !== 1'b0) begin n_err++; $display("FAIL credit_err_before got %b want 0", op_err); end
    w0 = wa_log.size();
    rx_read.rvalid = 1'b1; rx_read.rdata = '1;
    tick(); tick();
    n_vec++; if (op_err !== 1'b1) begin n_err++; $display("FAIL stray_err got %b want 1", op_err); end
    n_vec++; if (wa_log.size() != w0) begin n_err++; $display("FAIL stray_we got %0d writes want 0", wa_log.size() - w0); end
  endtask

  task automatic test_reset_drain();
    bit ok;
    int s0, r0;
    clear_logs();
    resp_budget = 0;
    start_op(42'h500, 16'd4, 9'd0, 2'b01);
    for (int i = 0; i < 30 && req_addr.size() == 0; i++) tick();
    tick(); tick();
    n_vec++; if (op_err !== 1'b0) begin n_err++; $display("FAIL start_clears_err got %b want 0", op_err); end
    n_vec++; if (op_ready !== 1'b0) begin n_err++; $display("FAIL drain_busy got %b want 0", op_ready); end
    resetn = 1'b0;
    #1;
    n_vec++; if (op_ready !== 1'b1 || tx_read.re !== 1'b0) begin
      n_err++; $display("FAIL rst_drain got ready=%b re=%b want 1/0", op_ready, tx_read.re); end
    n_vec++; if (op_done !== 1'b0 || wr_we !== 1'b0 || dma_control.start !== 1'b0) begin
      n_err++; $display("FAIL rst_drain_outs got done=%b we=%b start=%b want 0/0/0", op_done, wr_we, dma_control.start); end
    @(posedge clk); #1;
    resetn = 1'b1;
    s0 = start_cnt; r0 = req_addr.size();
    start_op(42'h600, 16'd0, 9'd0, 2'b01);
    run_until_done(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL zero_done got timeout want op_done"); end
    n_vec++; if (start_cnt != s0 || req_addr.size() != r0) begin
      n_err++; $display("FAIL zero_no_dma got starts=%0d reqs=%0d want 0/0", start_cnt - s0, req_addr.size() - r0); end
    n_vec++; if (op_err !== 1'b0) begin n_err++; $display("FAIL zero_err got %b want 0", op_err); end
    resp_budget = 1;
    tick(); tick();
    n_vec++; if (op_err !== 1'b1 || wa_log.size() != 0) begin
      n_err++; $display("FAIL post_rst_resp got err=%b writes=%0d want 1/0", op_err, wa_log.size()); end
    pend.delete();
    resp_budget = 1000000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_backpressure();
    test_credit();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dma_read_streamer.md
DMA_READ_STREAMER -- requirements
Module: dma_read_streamer

Interface
REQ-001 Parameter LOG2_DEPTH, default 9, SHALL set the fifobram write-address width.
REQ-002 Parameter MAX_OUTSTANDING, default 16, SHALL cap the number of cachelines requested but not yet returned.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  sole clock, rising edge
  resetn  in  1  asynchronous, active-low reset
  op_start  in  1  one-cycle start pulse
  op_addr  in  CLADDR_WIDTH  first cacheline address
  op_lines  in  16  cachelines to read
  op_waddr  in  LOG2_DEPTH  first fifobram write address
  op_wfifobram  in  2  wfifobram code to drive
  op_ready  out  1  high in IDLE
  op_done  out  1  one-cycle completion pulse
  op_err  out  1  sticky: rvalid received while nothing was outstanding
  dma_control  out  t_dma_control  to-DMA control
  dma_status  in  t_dma_status  DMA status
  tx_read  out  t_dma_tx_read  read requests
  rx_read  in  t_dma_rx_read  read responses
  wr_we, wr_waddr, wr_wdata, wr_wfifobram  out  1/LOG2_DEPTH/CLDATA_WIDTH/2  fifobram write port
  wr_almostfull  in  1  fifobram backpressure
  perf_busy, perf_stall  out  32/32  performance counters

Function
REQ-004 The FSM SHALL have states IDLE, ARM, WAIT_ACTIVE, REQUEST, DRAIN, DONE.
REQ-005 In IDLE, op_start SHALL latch all op_* inputs, clear op_err and go to ARM. If op_lines==0, it SHALL go directly to DONE with no DMA activity.
REQ-006 op_start outside IDLE SHALL be ignored.
REQ-007 ARM SHALL assert dma_control.start for exactly one cycle, with addr=op_addr, async=0 and regs=0, then go to WAIT_ACTIVE.
REQ-008 WAIT_ACTIVE SHALL hold until dma_status.active==1, then go to REQUEST.
REQ-009 In REQUEST, tx_read.re SHALL assert only when all of the following hold: remaining>0, !rx_read.ralmostfull, !wr_almostfull, and outstanding+burst<=MAX_OUTSTANDING.
REQ-010 Burst length selection SHALL be:
  - 4 lines (rlength=11) when remaining>=4 and raddr[1:0]==0;
  - otherwise 2 lines (01) when remaining>=2 and raddr[0]==0;
  - otherwise 1 line (00).
REQ-011 Each issued burst SHALL advance raddr by the burst length and decrement remaining by it.
REQ-012 When remaining reaches 0, the FSM SHALL go to DRAIN.
REQ-013 outstanding SHALL be updated by the net of issue (+burst) and rvalid (-1) in the same cycle; simultaneous events SHALL never be lost.
REQ-014 Each rx_read.rvalid SHALL produce, one cycle later:
  - wr_we=1 and wr_wdata=rdata;
  - wr_waddr = the current pointer, incrementing by 1 modulo 2^LOG2_DEPTH (wrapping to 0);
  - wr_wfifobram = the latched code.
Responses arrive in request order.
REQ-015 rvalid with outstanding==0 SHALL be dropped and SHALL set op_err.
REQ-016 DRAIN SHALL exit to DONE once outstanding==0 and the last wr_we has been issued.
REQ-017 DONE SHALL pulse op_done for one cycle, then return to IDLE. op_ready SHALL rise in the cycle after op_done.
REQ-018 tx_read.re and dma_control.start SHALL be 0 in every state other than REQUEST and ARM respectively.

Reset
REQ-019 On resetn low, the FSM SHALL go to IDLE immediately, and these outputs SHALL be 0: all counters, op_done, op_err, dma_control, tx_read, wr_we, wr_waddr, wr_wdata, perf_*. op_ready SHALL be 1 and wr_wfifobram SHALL be 01.
REQ-020 Reset mid-operation SHALL abandon the transfer. Responses arriving after reset SHALL be handled per REQ-015.

Configuration
REQ-021 With PIPEARCH_READ_PERF_EN defined:
  - perf_busy SHALL count cycles outside IDLE;
  - perf_stall SHALL count REQUEST cycles with remaining>0 and re==0;
  - both SHALL clear on accepted op_start and saturate at 2^32-1.
REQ-022 Without PIPEARCH_READ_PERF_EN, perf_busy and perf_stall SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-023 The state enum t_rdstream_state SHALL live in the shared common package. So SHALL the burst encodings, defined as constants RLEN_1=00, RLEN_2=01, RLEN_4=11.
REQ-024 Burst selection and address/remaining bookkeeping SHALL form one sub-module, dma_read_req_gen. The FSM, credit counter and write path SHALL stay in the top module.

Verification
REQ-025 op_addr=0x100, op_lines=8, no backpressure -> two 4-line requests. Eight wr_we follow at waddr op_waddr..+7, then one op_done.
REQ-026 op_addr=0x101, op_lines=7 -> bursts 1,2,4 at 0x101,0x102,0x104.
REQ-027 op_waddr=510, op_lines=4, LOG2_DEPTH=9 -> waddr sequence 510,511,0,1.
REQ-028 Hold ralmostfull=1 for 20 cycles mid-transfer -> re stays 0 during that window. The transfer completes with correct data order. perf_stall>=20 when the macro is defined.
REQ-029 Stretch response latency so outstanding=16 -> re blocked until an rvalid arrives. Then inject rvalid in IDLE -> op_err=1, no wr_we.
REQ-030 Deassert resetn during DRAIN -> op_ready=1 and tx_read.re=0 immediately. A new op_start with op_lines=0 then yields op_done with no dma_control.start.
